// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and FSM encoding for the display update arbiter
package vga_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int SCORE_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick from an eligibility mask and a start pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Walk upward from ptr with wrap; the first eligible requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!valid && elig[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_frame_update_arbiter.sv
// rtl/vga_frame_update_arbiter.sv - vblank-gated round-robin writer of the display's per-player shadow values
module vga_frame_update_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = NUM_PLAYERS,
    parameter int DATA_W  = SCORE_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vblank,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ*DATA_W-1:0]   disp_data,
    output logic [7:0]                  frame_cnt,
    output logic                        commit
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] served_q;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               pick_valid;
    logic               wrote_q;
    logic               start_frame;
    logic               issue_grant;
    logic               do_write;
    logic               commit_d;

    // Anyone already written this blank is masked until the next vblank entry.
    assign elig = req & ~served_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .elig   (elig),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        issue_grant = 1'b0;
        do_write    = 1'b0;
        commit_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vblank) begin
                    state_d     = ST_SCAN;
                    start_frame = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!vblank) begin
                    state_d  = ST_IDLE;
                    commit_d = wrote_q;
                end else if (pick_valid) begin
                    state_d     = ST_GRANT;
                    issue_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                // The write always completes even if vblank has just dropped.
                do_write = 1'b1;
                if (vblank) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d  = ST_IDLE;
                    commit_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            disp_data <= '0;
            served_q  <= '0;
            wrote_q   <= 1'b0;
            rr_ptr_q  <= '0;
            pick_q    <= '0;
            frame_cnt <= 8'd0;
            commit    <= 1'b0;
        end else begin
            commit <= commit_d;
            gnt    <= issue_grant ? pick_onehot : '0;
            if (start_frame) begin
                served_q  <= '0;
                wrote_q   <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (issue_grant) begin
                pick_q <= pick_idx;
            end
            if (do_write) begin
                disp_data[pick_q*DATA_W +: DATA_W] <= wdata[pick_q*DATA_W +: DATA_W];
                served_q[pick_q] <= 1'b1;
                wrote_q          <= 1'b1;
                rr_ptr_q         <= (pick_q == IDX_W'(NUM_REQ - 1)) ? '0 : pick_q + 1'b1;
            end
        end
    end

endmodule
